cordic_ctrl: RTL

CORDIC_CTRL -- requirements
Module: cordic_ctrl

---
 rtl/cordic_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/cordic_ctrl.sv
// CORDIC sequencer: IDLE -> LOAD -> ITER x ITERS -> [SCALE] -> DONE, handshaked start and result.
// Optional gain-compensation cycle is compiled in with CORDIC_CTRL_GAIN_COMP_EN (adds scale_en port).
module cordic_ctrl #(
    parameter int ITERS = 16,
    parameter int W     = 16,
    localparam int IW   = (W < 4) ? W : 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    mode,
    output logic          start_ready,
    input  logic          z_sign,
    input  logic          y_sign,
    output logic          load,
    output logic          step_en,
    output logic [IW-1:0] iter,
    output logic          dir,
    output logic [3:0]    select,
    output logic          out_valid,
    input  logic          out_ready
`ifdef CORDIC_CTRL_GAIN_COMP_EN
    ,
    output logic          scale_en
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_SCALE,
        S_DONE
    } state_t;

    localparam logic [IW-1:0] LAST_ITER = IW'(ITERS - 1);

    state_t        state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic [3:0]    select_q, select_d;
    logic [IW-1:0] iter_q, iter_d;
    logic          load_q, load_d;
    logic          step_en_q, step_en_d;
    logic          out_valid_q, out_valid_d;
    logic          start_ready_q, start_ready_d;
`ifdef CORDIC_CTRL_GAIN_COMP_EN
    logic          scale_en_q, scale_en_d;
`endif

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        select_d = select_q;
        iter_d   = iter_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_LOAD;
                    mode_d   = mode;
                    select_d = 4'b0001 << mode;
                    iter_d   = '0;
                end
            end
            S_LOAD: state_d = S_ITER;
            S_ITER: begin
                if (iter_q == LAST_ITER) begin
`ifdef CORDIC_CTRL_GAIN_COMP_EN
                    state_d = S_SCALE;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    iter_d = iter_q + 1'b1;
                end
            end
`ifdef CORDIC_CTRL_GAIN_COMP_EN
            S_SCALE: state_d = S_DONE;
`endif
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they leave a flop in step with the state.
        load_d        = (state_d == S_LOAD);
        step_en_d     = (state_d == S_ITER);
        out_valid_d   = (state_d == S_DONE);
        start_ready_d = (state_d == S_IDLE);
`ifdef CORDIC_CTRL_GAIN_COMP_EN
        scale_en_d    = (state_d == S_SCALE);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            mode_q        <= 2'd0;
            select_q      <= 4'b0001;
            iter_q        <= '0;
            load_q        <= 1'b0;
            step_en_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            start_ready_q <= 1'b1;
`ifdef CORDIC_CTRL_GAIN_COMP_EN
            scale_en_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            select_q      <= select_d;
            iter_q        <= iter_d;
            load_q        <= load_d;
            step_en_q     <= step_en_d;
            out_valid_q   <= out_valid_d;
            start_ready_q <= start_ready_d;
`ifdef CORDIC_CTRL_GAIN_COMP_EN
            scale_en_q    <= scale_en_d;
`endif
        end
    end

    // Rotation drives z toward zero, vectoring drives y toward zero.
    always_comb begin
        dir = 1'b0;
        if (state_q == S_ITER) dir = mode_q[1] ? y_sign : ~z_sign;
    end

    assign start_ready = start_ready_q;
    assign load        = load_q;
    assign step_en     = step_en_q;
    assign iter        = iter_q;
    assign select      = select_q;
    assign out_valid   = out_valid_q;
`ifdef CORDIC_CTRL_GAIN_COMP_EN
    assign scale_en    = scale_en_q;
`endif

endmodule
